// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encodings,
// memory access size codes and the byte-lane helper functions used by the
// load/store lane logic.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Byte enables; low address bits beyond the access size are ignored.
    function automatic logic [3:0] st_strobe(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane so any strobe sees the right byte(s).
    function automatic logic [31:0] st_replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Pick the addressed lane out of the load word and sign/zero-extend it.
    function automatic logic [31:0] ld_extend(input logic [1:0] size, input logic [1:0] a,
                                             input logic [31:0] rdata, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    return {{24{b[7] & ~uns}}, b};
            SZ_H:    return {{16{h[15] & ~uns}}, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/mc_lsu_lane.sv
// Combinational load/store lane unit: store strobes and data replication,
// load lane select and extension. Kept stateless so a pipelined core can
// reuse it directly.
module mc_lsu_lane
    import mc_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    input  logic        load_uns_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    // Store side: byte enables and lane-replicated write data.
    always_comb begin
        wstrb_o = st_strobe(size_i, addr_lo_i);
        wdata_o = st_replicate(size_i, st_data_i);
    end

    // Load side: lane select plus sign/zero extension.
    always_comb begin
        ld_data_o = ld_extend(size_i, addr_lo_i, rdata_i, load_uns_i);
    end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer: owns PC, IR and the IF/ID/EXE/MEM/WB FSM, drives the
// instruction/data SRAM req/ack handshakes and guards them with a watchdog.
// Optional MC_PERF_CNT_EN adds cycle and retired-instruction counters.
module mc_seq_ctrl
    import mc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h1c000000),
    parameter int                MAX_WAIT = 255,
    parameter int                WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cls_branch,
    input  logic              cls_load,
    input  logic              cls_store,
    input  logic              cls_wb,
    input  logic [1:0]        mem_size,
    input  logic              load_uns,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       st_data,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ack,
    input  logic [31:0]       inst_rdata,
    output logic              data_req,
    output logic              data_we,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_ack,
    input  logic [31:0]       data_rdata,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              rf_we,
    output logic [31:0]       load_result,
    output logic              retire,
    output logic              bus_err
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       inst_cnt
`endif
);

    // Error fires on the last unacknowledged cycle, so req is high MAX_WAIT cycles.
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       ld_q, ld_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic              ireq_c, dreq_c, rfwe_c, ret_c, wd_expire;
    logic [ADDR_W-1:0] pc_seq, pc_redir;
    logic [3:0]        lane_strb;
    logic [31:0]       lane_wdata, lane_ld;

    mc_lsu_lane u_lane (
        .size_i     (mem_size),
        .addr_lo_i  (mem_addr[1:0]),
        .st_data_i  (st_data),
        .rdata_i    (data_rdata),
        .load_uns_i (load_uns),
        .wstrb_o    (lane_strb),
        .wdata_o    (lane_wdata),
        .ld_data_o  (lane_ld)
    );

    assign pc_seq    = pc_q + ADDR_W'(4);
    assign pc_redir  = br_taken ? br_target : pc_seq;
    assign wd_expire = (MAX_WAIT != 0) && (wait_q == WAIT_LIM);

    // Next-state, PC/IR/load updates, handshake strobes and watchdog counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ld_d    = ld_q;
        err_d   = err_q;
        wait_d  = wait_q;
        ireq_c  = 1'b0;
        dreq_c  = 1'b0;
        rfwe_c  = 1'b0;
        ret_c   = 1'b0;
        // A latched bus error freezes the FSM until reset.
        if (!err_q) begin
            case (state_q)
                S_IF: begin
                    ireq_c = 1'b1;
                    if (inst_ack) begin
                        ir_d    = inst_rdata;
                        state_d = S_ID;
                    end else if (wd_expire) begin
                        err_d = 1'b1;
                    end
                end
                S_ID: begin
                    if (cls_branch) begin
                        pc_d    = pc_redir;
                        ret_c   = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_EXE;
                    end
                end
                S_EXE: state_d = (cls_load | cls_store) ? S_MEM : S_WB;
                S_MEM: begin
                    dreq_c = 1'b1;
                    if (data_ack) begin
                        if (cls_load) begin
                            ld_d    = lane_ld;
                            state_d = S_WB;
                        end else begin
                            pc_d    = pc_seq;
                            ret_c   = 1'b1;
                            state_d = S_IF;
                        end
                    end else if (wd_expire) begin
                        err_d = 1'b1;
                    end
                end
                S_WB: begin
                    rfwe_c  = cls_wb;
                    pc_d    = pc_redir;
                    ret_c   = 1'b1;
                    state_d = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
        // Any state change restarts the wait count for the next handshake.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((ireq_c && !inst_ack) || (dreq_c && !data_ack)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ld_q    <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ld_q    <= ld_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Handshake and pulse outputs are masked while reset is held so no stale
    // request or write escapes during reset.
    assign inst_req    = ireq_c & ~reset;
    assign data_req    = dreq_c & ~reset;
    assign data_we     = data_req & cls_store;
    assign data_wstrb  = data_we ? lane_strb : 4'b0000;
    assign data_wdata  = lane_wdata;
    assign data_addr   = {mem_addr[ADDR_W-1:2], 2'b00};
    assign inst_addr   = pc_q;
    assign rf_we       = rfwe_c & ~reset;
    assign retire      = ret_c & ~reset;
    assign ir          = ir_q;
    assign pc          = pc_q;
    assign state       = state_q;
    assign load_result = ld_q;
    assign bus_err     = err_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q, inst_q;

    // Free-running performance counters, frozen once a bus error is latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else if (!err_q) begin
            cyc_q <= cyc_q + 32'd1;
            if (ret_c) inst_q <= inst_q + 32'd1;
        end
    end

    assign cyc_cnt  = cyc_q;
    assign inst_cnt = inst_q;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed testbench for mc_seq_ctrl (watchdog limit set to 4 cycles).
// Build with MC_PERF_CNT_EN defined to also exercise the perf counters.
module tb_mc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cls_branch, cls_load, cls_store, cls_wb;
    logic [1:0]  mem_size;
    logic        load_uns, br_taken;
    logic [31:0] br_target, mem_addr, st_data;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req, data_we;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic [31:0] ir, pc;
    logic [2:0]  state;
    logic        rf_we;
    logic [31:0] load_result;
    logic        retire, bus_err;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, inst_cnt;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    mc_seq_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC), .MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cls_branch(cls_branch), .cls_load(cls_load), .cls_store(cls_store), .cls_wb(cls_wb),
        .mem_size(mem_size), .load_uns(load_uns), .br_taken(br_taken), .br_target(br_target),
        .mem_addr(mem_addr), .st_data(st_data),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .ir(ir), .pc(pc), .state(state), .rf_we(rf_we), .load_result(load_result),
        .retire(retire), .bus_err(bus_err)
`ifdef MC_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        cls_branch = 0; cls_load = 0; cls_store = 0; cls_wb = 0;
        mem_size = 2'd2; load_uns = 0; br_taken = 0; br_target = '0;
        mem_addr = '0; st_data = '0; inst_ack = 0; inst_rdata = '0;
        data_ack = 0; data_rdata = '0;
    endtask

    // Two reset edges, release just after an edge so the next full cycle is IF.
    task automatic do_reset;
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, RST_PC); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir got=%h exp=0", ir); end
        checks++; if (load_result !== 32'h0) begin errors++; $display("FAIL rst_ldres got=%h exp=0", load_result); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_buserr got=%b exp=0", bus_err); end
        checks++; if ({inst_req, data_req, data_we, data_wstrb, rf_we, retire} !== 9'h0)
            begin errors++; $display("FAIL rst_strobes got=%b exp=0", {inst_req, data_req, data_we, data_wstrb, rf_we, retire}); end
    endtask

    task automatic test_alu;
        logic [2:0] exp_st [0:4] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        int ret_cnt = 0;
        do_reset();
        cls_wb = 1; inst_ack = 1; inst_rdata = 32'h02800421;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL alu_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
            checks++; if (rf_we !== (i == 3)) begin errors++; $display("FAIL alu_rfwe[%0d] got=%b exp=%b", i, rf_we, (i == 3)); end
            ret_cnt += int'(retire);
            if (i == 1) begin
                checks++; if (ir !== 32'h02800421) begin errors++; $display("FAIL alu_ir got=%h exp=02800421", ir); end
            end
        end
        checks++; if (ret_cnt != 1) begin errors++; $display("FAIL alu_retire_cnt got=%0d exp=1", ret_cnt); end
        checks++; if (pc !== 32'h1c000004) begin errors++; $display("FAIL alu_pc got=%h exp=1c000004", pc); end
    endtask

    task automatic test_branch;
        do_reset();
        cls_branch = 1; br_taken = 1; br_target = 32'h1c000100; inst_ack = 1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (state !== 3'd1 || retire !== 1'b1 || rf_we !== 1'b0 || data_req !== 1'b0)
            begin errors++; $display("FAIL beq_id got st=%0d ret=%b rfwe=%b dreq=%b exp st=1 ret=1 rfwe=0 dreq=0", state, retire, rf_we, data_req); end
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL beq_state got=%0d exp=0", state); end
        checks++; if (pc !== 32'h1c000100) begin errors++; $display("FAIL beq_taken_pc got=%h exp=1c000100", pc); end
        br_taken = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pc !== 32'h1c000104) begin errors++; $display("FAIL beq_nt_pc got=%h exp=1c000104", pc); end
    endtask

    task automatic test_store;
        int req_cnt = 0;
        do_reset();
        cls_store = 1; mem_size = 2'd0; mem_addr = 32'h80001003; st_data = 32'h000000A5; inst_ack = 1;
        @(negedge clk);
        @(negedge clk); inst_ack = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_cnt += int'(data_req);
            if (i == 0) begin
                checks++; if (data_wstrb !== 4'b1000) begin errors++; $display("FAIL stb_wstrb got=%b exp=1000", data_wstrb); end
                checks++; if (data_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL stb_wdata got=%h exp=a5a5a5a5", data_wdata); end
                checks++; if (data_addr !== 32'h80001000 || data_we !== 1'b1)
                    begin errors++; $display("FAIL stb_addr got=%h we=%b exp=80001000 we=1", data_addr, data_we); end
            end
            if (i == 3) begin
                data_ack = 1;
                #1;
                checks++; if (retire !== 1'b1) begin errors++; $display("FAIL stb_retire got=%b exp=1", retire); end
            end
        end
        @(negedge clk);
        checks++; if (req_cnt != 4 || data_req !== 1'b0) begin errors++; $display("FAIL stb_req_cycles got=%0d req_now=%b exp=4 req_now=0", req_cnt, data_req); end
        checks++; if (state !== 3'd0 || pc !== 32'h1c000004) begin errors++; $display("FAIL stb_done got st=%0d pc=%h exp st=0 pc=1c000004", state, pc); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL stb_ack_at_limit got=%b exp=0", bus_err); end
        // Half store at the upper half, acknowledged immediately.
        mem_size = 2'd1; mem_addr = 32'h80001002; st_data = 32'h1234BEEF; inst_ack = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (state !== 3'd3 || data_wstrb !== 4'b1100 || data_wdata !== 32'hBEEFBEEF)
            begin errors++; $display("FAIL sth got st=%0d wstrb=%b wdata=%h exp st=3 wstrb=1100 wdata=beefbeef", state, data_wstrb, data_wdata); end
        @(negedge clk);
        checks++; if (pc !== 32'h1c000008) begin errors++; $display("FAIL sth_pc got=%h exp=1c000008", pc); end
    endtask

    task automatic test_load;
        do_reset();
        cls_load = 1; cls_wb = 1; mem_size = 2'd1; mem_addr = 32'h80001002;
        data_rdata = 32'h80011234; load_uns = 0; inst_ack = 1; data_ack = 1;
        repeat (5) @(negedge clk);
        checks++; if (state !== 3'd4 || rf_we !== 1'b1) begin errors++; $display("FAIL ldh_wb got st=%0d rfwe=%b exp st=4 rfwe=1", state, rf_we); end
        checks++; if (load_result !== 32'hFFFF8001) begin errors++; $display("FAIL ldh_signed got=%h exp=ffff8001", load_result); end
        @(negedge clk);
        load_uns = 1;
        repeat (4) @(negedge clk);
        checks++; if (state !== 3'd4 || rf_we !== 1'b1) begin errors++; $display("FAIL ldhu_wb got st=%0d rfwe=%b exp st=4 rfwe=1", state, rf_we); end
        checks++; if (load_result !== 32'h00008001) begin errors++; $display("FAIL ldhu_unsigned got=%h exp=00008001", load_result); end
    endtask

    task automatic test_watchdog;
        int req_cnt = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_cnt += int'(inst_req);
            if (i == 3) begin
                checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL wd_early got=%b exp=0", bus_err); end
            end
        end
        @(negedge clk);
        checks++; if (req_cnt != 4) begin errors++; $display("FAIL wd_req_cycles got=%0d exp=4", req_cnt); end
        checks++; if (bus_err !== 1'b1 || inst_req !== 1'b0) begin errors++; $display("FAIL wd_err got err=%b req=%b exp err=1 req=0", bus_err, inst_req); end
        inst_ack = 1; inst_rdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        checks++; if (state !== 3'd0 || ir !== 32'h0) begin errors++; $display("FAIL wd_hold got st=%0d ir=%h exp st=0 ir=0", state, ir); end
        test_reset();
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf;
        do_reset();
        cls_wb = 1; inst_ack = 1; inst_rdata = 32'h02800421;
        repeat (41) @(negedge clk);
        checks++; if (inst_cnt !== 32'd10) begin errors++; $display("FAIL perf_inst got=%0d exp=10", inst_cnt); end
        checks++; if (cyc_cnt !== 32'd40) begin errors++; $display("FAIL perf_cyc got=%0d exp=40", cyc_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_store();
        test_load();
        test_watchdog();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
